// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache/memory arbiter: FSM states,
// owner encoding and the line-offset width derivation.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST_IC = 2'd1,
    BURST_DC = 2'd2
  } state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // Byte-offset bits within a line of 4-byte words.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache refill and D-cache
// refill/writeback; each grant is a whole-line burst, round-robin on ties.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;

  logic in_burst, is_ic, is_dc, final_ack;

  assign is_ic     = (state_q == BURST_IC);
  assign is_dc     = (state_q == BURST_DC);
  assign in_burst  = is_ic | is_dc;
  assign final_ack = in_burst & mem_ack & (cnt_q == CNT_LAST);

  always_comb begin
    logic take_dc;
    take_dc = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (ic_req | dc_req) begin
          // On a tie the requester not served last wins.
          take_dc = dc_req & (~ic_req | (last_q == OWN_IC));
          state_d = take_dc ? BURST_DC : BURST_IC;
          last_d  = take_dc ? OWN_DC : OWN_IC;
          base_d  = (take_dc ? dc_addr : ic_addr) & ~OFF_MASK;
          cnt_d   = '0;
          we_d    = take_dc & dc_we;
        end
      end
      BURST_IC, BURST_DC: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= OWN_IC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line base and direction only matter while a burst is live.
  always_ff @(posedge clock) begin
    base_q <= base_d;
    we_q   <= we_d;
  end

  assign mem_req   = in_burst;
  assign mem_we    = is_dc & we_q;
  assign mem_addr  = in_burst ? (base_q + ADDR_W'({cnt_q, 2'b00})) : '0;
  assign mem_wdata = in_burst ? dc_wdata : '0;

  assign ic_gnt    = is_ic;
  assign ic_rvalid = is_ic & mem_ack;
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_done   = is_ic & final_ack;

  assign dc_gnt    = is_dc;
  assign dc_rvalid = is_dc & ~we_q & mem_ack;
  assign dc_wnext  = is_dc & we_q & mem_ack;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_done   = is_dc & final_ack;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: burst-level reference model checked
// every cycle, plus literal expectations on addresses, order and latency.
module tb_cache_mem_arbiter;

  localparam int LW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_gnt, ic_rvalid, ic_done;
  logic [31:0] ic_rdata;
  logic        dc_gnt, dc_wnext, dc_rvalid, dc_done;
  logic [31:0] dc_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   wait_n = 0;
  int   wcnt = 0;
  int   widx = 0;
  logic force_ack = 1'b0;
  bit   chk_on = 1'b0;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: acks after wait_n idle cycles of a held request.
  assign mem_ack   = force_ack | (mem_req & (wcnt >= wait_n));
  assign mem_rdata = mem_ack ? memword(mem_addr) : 32'hBAD0_BAD0;
  always @(posedge clock) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Writeback source: 0xA0.. advancing on each consumed word.
  always @(posedge clock) widx <= !dc_req ? 0 : widx + int'(dc_wnext);
  assign dc_wdata = 32'h0000_00A0 + 32'(widx);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = no owner, 1 = I-cache, 2 = D-cache.
  int          m_owner = 0, m_k = 0, m_last = 1;
  logic [31:0] m_base = '0;
  logic        m_we = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_owner = 0; m_k = 0; m_last = 1;
    end else if (m_owner == 0) begin
      if (ic_req && dc_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (ic_req)      m_owner = 1;
      else if (dc_req)      m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner;
        m_base = ((m_owner == 1) ? ic_addr : dc_addr) & ~32'(LW * 4 - 1);
        m_k    = 0;
        m_we   = (m_owner == 2) && dc_we;
      end
    end else if (mem_ack) begin
      m_k++;
      if (m_k == LW) m_owner = 0;
    end
  end

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
  acc_t log_q[$];
  int   ic_rv_n = 0, dc_rv_n = 0, done_n = 0, done_cyc = 0;

  always @(negedge clock) begin
    logic [31:0] ea;
    logic        busy, icrv, dcrv, dcwn;
    if (chk_on) begin
      busy = (m_owner != 0);
      ea   = busy ? m_base + 32'(4 * m_k) : 32'h0;
      icrv = (m_owner == 1) && mem_ack;
      dcrv = (m_owner == 2) && !m_we && mem_ack;
      dcwn = (m_owner == 2) && m_we && mem_ack;
      chk("mem_req",   mem_req,   busy);
      chk("mem_addr",  mem_addr,  ea);
      chk("mem_we",    mem_we,    (m_owner == 2) && m_we);
      chk("mem_wdata", mem_wdata, busy ? dc_wdata : 32'h0);
      chk("ic_gnt",    ic_gnt,    m_owner == 1);
      chk("ic_rvalid", ic_rvalid, icrv);
      chk("ic_rdata",  ic_rdata,  icrv ? memword(ea) : 32'h0);
      chk("ic_done",   ic_done,   icrv && (m_k == LW - 1));
      chk("dc_gnt",    dc_gnt,    m_owner == 2);
      chk("dc_rvalid", dc_rvalid, dcrv);
      chk("dc_wnext",  dc_wnext,  dcwn);
      chk("dc_rdata",  dc_rdata,  dcrv ? memword(ea) : 32'h0);
      chk("dc_done",   dc_done,   (dcrv || dcwn) && (m_k == LW - 1));
      chk("gnt_excl",  ic_gnt & dc_gnt, 1'b0);
      if (mem_req && mem_ack) log_q.push_back('{mem_addr, mem_we, mem_wdata});
      if (ic_rvalid) ic_rv_n++;
      if (dc_rvalid) dc_rv_n++;
      if (ic_done || dc_done) begin done_n++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_done(input bit dc, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      seen = dc ? dc_done : ic_done;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_done: got no %s_done within %0d cycles", dc ? "dc" : "ic", budget);
    end
    tick();
  endtask

  task automatic wait_any(input int budget, output int who);
    who = 0;
    for (int i = 0; i < budget && who == 0; i++) begin
      @(negedge clock);
      if (dc_done) who = 2;
      else if (ic_done) who = 1;
    end
    tick();
  endtask

  task automatic chk_log(input int idx, input logic [31:0] a, input logic we, input logic [31:0] wd);
    n_chk++;
    if (idx >= log_q.size()) begin
      n_fail++;
      $display("FAIL log_entry: got %0d accesses, required entry %0d", log_q.size(), idx);
    end else begin
      chk("log_addr", log_q[idx].addr, a);
      chk("log_we", {31'b0, log_q[idx].we}, {31'b0, we});
      if (we) chk("log_wdata", log_q[idx].wdata, wd);
    end
  endtask

  initial begin
    int mark, mark2, c0, d0, who, rv0;
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0;
    tick();
    chk_on = 1'b1;
    @(negedge clock);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ic_gnt", ic_gnt, 1'b0);
    chk("rst_dc_gnt", dc_gnt, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Lone I-cache miss, zero-wait memory
    mark = log_q.size(); rv0 = ic_rv_n;
    ic_addr = 32'h104; ic_req = 1'b1; c0 = cyc;
    wait_done(1'b0, 20);
    ic_req = 1'b0;
    chk("t1_latency", done_cyc - c0, LW);
    chk("t1_rvalids", ic_rv_n - rv0, 4);
    for (int i = 0; i < 4; i++) chk_log(mark + i, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
    tick();

    // Simultaneous requests after reset: D-cache first
    mark = log_q.size();
    ic_addr = 32'h500; dc_addr = 32'h200; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    wait_done(1'b1, 20);
    dc_req = 1'b0;
    tick();
    chk("t2_ic_gnt", ic_gnt, 1'b1);
    wait_done(1'b0, 20);
    ic_req = 1'b0;
    for (int i = 0; i < 4; i++) chk_log(mark + i, 32'h200 + 32'(4 * i), 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) chk_log(mark + 4 + i, 32'h500 + 32'(4 * i), 1'b0, 32'h0);
    tick();

    // Round-robin with both requesting continuously
    ic_addr = 32'h600; dc_addr = 32'h800;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_any(20, who);
      chk("t3_order", who, (i % 2 == 0) ? 2 : 1);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    tick();

    // Writeback with the memory acking every 3rd cycle
    mark = log_q.size();
    wait_n = 2; dc_we = 1'b1; dc_addr = 32'h300; dc_req = 1'b1; c0 = cyc;
    wait_done(1'b1, 40);
    dc_req = 1'b0; dc_we = 1'b0; wait_n = 0;
    chk("t4_latency", done_cyc - c0, 12);
    for (int i = 0; i < 4; i++)
      chk_log(mark + i, 32'h300 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i));
    tick();

    // Reset after the 2nd ack of an I-cache burst
    mark = log_q.size(); d0 = done_n;
    ic_addr = 32'h704; ic_req = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_ic_gnt", ic_gnt, 1'b0);
    chk("t5_ic_rvalid", ic_rvalid, 1'b0);
    chk("t5_no_done", done_n - d0, 0);
    chk("t5_words_before", log_q.size() - mark, 3);
    mark2 = log_q.size();
    wait_done(1'b0, 20);
    ic_req = 1'b0;
    chk("t5_restart_words", log_q.size() - mark2, 4);
    chk_log(mark2, 32'h700, 1'b0, 32'h0);
    tick();

    // Spurious ack in IDLE, then D-cache drops req mid-burst
    rv0 = ic_rv_n + dc_rv_n; d0 = done_n;
    force_ack = 1'b1;
    tick(); tick();
    force_ack = 1'b0;
    chk("t6_idle_rvalid", ic_rv_n + dc_rv_n - rv0, 0);
    chk("t6_idle_done", done_n - d0, 0);
    mark = log_q.size(); rv0 = dc_rv_n;
    dc_we = 1'b0; dc_addr = 32'h404; dc_req = 1'b1;
    tick(); tick();
    dc_req = 1'b0; dc_addr = 32'hFFF0;
    wait_done(1'b1, 20);
    chk("t6_rvalids", dc_rv_n - rv0, 4);
    for (int i = 0; i < 4; i++) chk_log(mark + i, 32'h400 + 32'(4 * i), 1'b0, 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
